// File: rtl/daq_pkg.sv
// Shared types for the DAQ stream path: the frame header layout and the depacketizer states.
package daq_pkg;

   localparam int unsigned HDR_W  = 32;
   localparam int unsigned CHAN_W = 8;
   localparam int unsigned SEQ_W  = 4;
   localparam int unsigned LEN_W  = 12;
   localparam int unsigned CNT_W  = 16;

   localparam logic [7:0] DEPKT_SYNC = 8'hA5;

   typedef struct packed {
      logic [7:0]       sync;
      logic [CHAN_W-1:0] chan;
      logic [SEQ_W-1:0]  seq;
      logic [LEN_W-1:0]  len;
   } hdr_t;

   typedef enum logic [1:0] {
      HDR,
      PAYLOAD,
      DROP
   } depkt_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry registered AXI-Stream stage carrying data/last/user with a valid/ready handshake.
module axis_out_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned USER_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic [USER_W-1:0] s_user,
   input  logic              s_valid,
   output logic              s_ready_c,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic [USER_W-1:0] m_user,
   output logic              m_valid,
   input  logic              m_ready
);

   // Accept a new word whenever the slot is empty or is draining this cycle.
   assign s_ready_c = !m_valid || m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
         m_user  <= '0;
      end else if (s_valid && s_ready_c) begin
         m_valid <= 1'b1;
         m_data  <= s_data;
         m_last  <= s_last;
         m_user  <= s_user;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_depacketizer.sv
// Strips and checks frame headers, forwards payload with tuser = channel and a rebuilt tlast,
// flags framing errors and keeps saturating frame/error counters.
module axis_depacketizer
   import daq_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned USER_W  = 8,
   parameter int unsigned MAX_LEN = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tlast,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic [USER_W-1:0] m_tuser,
   output logic              hdr_valid,
   output logic [CHAN_W-1:0] hdr_chan,
   output logic              err_sync,
   output logic              err_len,
   output logic              err_seq,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   depkt_state_e      state, state_n;
   logic [LEN_W-1:0]  rem, rem_n;
   logic [CHAN_W-1:0] hdr_chan_n;
   logic [SEQ_W-1:0]  exp_seq, exp_seq_n;
   logic              seq_known, seq_known_n;

   hdr_t hdr_c;
   logic sync_ok_c, len_bad_c;
   logic push_c, push_last_c, out_ready_c;
   logic hdr_valid_c, err_sync_c, err_len_c, err_seq_c, frame_done_c;

   assign hdr_c     = hdr_t'(s_tdata[HDR_W-1:0]);
   assign sync_ok_c = (hdr_c.sync == DEPKT_SYNC);
   assign len_bad_c = (hdr_c.len == '0) || (hdr_c.len > MAX_LEN_L);

   // Next-state, handshake and event decode.
   always_comb begin
      state_n      = state;
      rem_n        = rem;
      hdr_chan_n   = hdr_chan;
      exp_seq_n    = exp_seq;
      seq_known_n  = seq_known;
      s_tready     = 1'b1;
      push_c       = 1'b0;
      push_last_c  = 1'b0;
      hdr_valid_c  = 1'b0;
      err_sync_c   = 1'b0;
      err_len_c    = 1'b0;
      err_seq_c    = 1'b0;
      frame_done_c = 1'b0;
      case (state)
         HDR: begin
            if (s_tvalid) begin
               if (sync_ok_c) begin
                  exp_seq_n   = hdr_c.seq + SEQ_W'(1);
                  seq_known_n = 1'b1;
                  err_seq_c   = seq_known && (hdr_c.seq != exp_seq);
               end
               if (!sync_ok_c || len_bad_c) begin
                  err_sync_c = !sync_ok_c;
                  err_len_c  = len_bad_c;
                  state_n    = s_tlast ? HDR : DROP;
               end else if (s_tlast) begin
                  err_len_c = 1'b1;
               end else begin
                  hdr_chan_n  = hdr_c.chan;
                  rem_n       = hdr_c.len;
                  hdr_valid_c = 1'b1;
                  state_n     = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            s_tready = out_ready_c;
            if (s_tvalid && out_ready_c) begin
               push_c      = 1'b1;
               push_last_c = s_tlast || (rem == LEN_W'(1));
               if (rem == LEN_W'(1)) begin
                  frame_done_c = s_tlast;
                  err_len_c    = !s_tlast;
                  state_n      = s_tlast ? HDR : DROP;
               end else if (s_tlast) begin
                  err_len_c = 1'b1;
                  state_n   = HDR;
               end else begin
                  rem_n = rem - LEN_W'(1);
               end
            end
         end
         DROP: begin
            if (s_tvalid && s_tlast) state_n = HDR;
         end
         default: state_n = HDR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HDR;
         rem       <= '0;
         hdr_chan  <= '0;
         exp_seq   <= '0;
         seq_known <= 1'b0;
         hdr_valid <= 1'b0;
         err_sync  <= 1'b0;
         err_len   <= 1'b0;
         err_seq   <= 1'b0;
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         state     <= state_n;
         rem       <= rem_n;
         hdr_chan  <= hdr_chan_n;
         exp_seq   <= exp_seq_n;
         seq_known <= seq_known_n;
         hdr_valid <= hdr_valid_c;
         err_sync  <= err_sync_c;
         err_len   <= err_len_c;
         err_seq   <= err_seq_c;
         if (frame_done_c) frame_cnt <= sat_inc(frame_cnt);
         // Several error kinds in one cycle count as a single event.
         if (err_sync_c || err_len_c || err_seq_c) err_cnt <= sat_inc(err_cnt);
      end
   end

   axis_out_reg #(
      .DATA_W (DATA_W),
      .USER_W (USER_W)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .s_data    (s_tdata),
      .s_last    (push_last_c),
      .s_user    (USER_W'(hdr_chan)),
      .s_valid   (push_c),
      .s_ready_c (out_ready_c),
      .m_data    (m_tdata),
      .m_last    (m_tlast),
      .m_user    (m_tuser),
      .m_valid   (m_tvalid),
      .m_ready   (m_tready)
   );

endmodule

// File: tb/tb_axis_depacketizer.sv
// Directed bench for axis_depacketizer: a table of frames with hand-computed results plus reset sequences.
module tb_axis_depacketizer;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned USER_W  = 8;
   localparam int unsigned MAX_LEN = 256;
   localparam int NV = 15;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] s_tdata = '0;
   logic              s_tvalid = 1'b0;
   logic              s_tready;
   logic              s_tlast = 1'b0;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready = 1'b1;
   logic              m_tlast;
   logic [USER_W-1:0] m_tuser;
   logic              hdr_valid;
   logic [7:0]        hdr_chan;
   logic              err_sync, err_len, err_seq;
   logic [15:0]       frame_cnt, err_cnt;

   axis_depacketizer #(.DATA_W(DATA_W), .USER_W(USER_W), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
      .hdr_valid(hdr_valid), .hdr_chan(hdr_chan),
      .err_sync(err_sync), .err_len(err_len), .err_seq(err_seq),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] hdr;
      int          nw;
      bit          hlast;
      bit          stall;
      int          exp_out;
      int          hv, es, el, eq;
      int          fc, ec;
   } vec_t;

   vec_t vt [NV];

   logic [31:0] out_q [$];
   logic        last_q [$];
   logic [7:0]  user_q [$];
   int hv_cnt, es_cnt, el_cnt, eq_cnt;
   bit stall_mode = 1'b0;
   bit hold_low = 1'b0;
   bit stalled_prev = 1'b0;
   logic [31:0] held_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      out_q.delete(); last_q.delete(); user_q.delete();
      hv_cnt = 0; es_cnt = 0; el_cnt = 0; eq_cnt = 0;
   endtask

   // Ready pattern: held low, toggling, or high.
   initial forever begin
      @(posedge clk); #1;
      m_tready = hold_low ? 1'b0 : (stall_mode ? ~m_tready : 1'b1);
   end

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_tvalid && m_tready) begin
            out_q.push_back(m_tdata);
            last_q.push_back(m_tlast);
            user_q.push_back(m_tuser);
         end
         if (hdr_valid) hv_cnt++;
         if (err_sync)  es_cnt++;
         if (err_len)   el_cnt++;
         if (err_seq)   eq_cnt++;
         if (stalled_prev) begin
            check("stall_hold_valid", 64'(m_tvalid), 64'd1);
            check("stall_hold_data", 64'(m_tdata), 64'(held_data));
         end
         stalled_prev = m_tvalid && !m_tready;
         held_data    = m_tdata;
      end else begin
         stalled_prev = 1'b0;
      end
   end

   task automatic send(input logic [31:0] d, input logic l);
      bit done = 1'b0;
      int t = 0;
      s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
      while (!done && t < 200) begin
         @(negedge clk);
         done = s_tready;
         @(posedge clk); #1;
         t++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      if (!done) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout: word %0h not accepted within 200 cycles", d);
      end
   endtask

   function automatic logic [31:0] pay(input int k, input int i);
      return {8'hD0, 8'(k), 16'(i)};
   endfunction

   initial begin
      //          hdr           nw  hl st out hv es el eq fc ec
      vt[0]  = '{32'hA503_0004,   4, 0, 0,   4, 1, 0, 0, 0, 1, 0};
      vt[1]  = '{32'hA503_1004,   4, 0, 1,   4, 1, 0, 0, 0, 2, 0};
      vt[2]  = '{32'hA503_2004,   2, 0, 0,   2, 1, 0, 1, 0, 2, 1};
      vt[3]  = '{32'hA507_3002,   5, 0, 0,   2, 1, 0, 1, 0, 2, 2};
      vt[4]  = '{32'h5A03_4003,   3, 0, 0,   0, 0, 1, 0, 0, 2, 3};
      vt[5]  = '{32'hA503_4001,   1, 0, 0,   1, 1, 0, 0, 0, 3, 3};
      vt[6]  = '{32'hA501_5000,   2, 0, 0,   0, 0, 0, 1, 0, 3, 4};
      vt[7]  = '{32'hA501_6101,   1, 0, 0,   0, 0, 0, 1, 0, 3, 5};
      vt[8]  = '{32'hA502_7100, 256, 0, 0, 256, 1, 0, 0, 0, 4, 5};
      vt[9]  = '{32'hA503_9001,   1, 0, 0,   1, 1, 0, 0, 1, 5, 6};
      vt[10] = '{32'hA503_A002,   0, 1, 0,   0, 0, 0, 1, 0, 5, 7};
      vt[11] = '{32'hA503_B001,   1, 0, 0,   1, 1, 0, 0, 0, 6, 7};
      vt[12] = '{32'hA503_C001,   1, 0, 0,   1, 1, 0, 0, 0, 7, 7};
      vt[13] = '{32'hA503_E001,   1, 0, 0,   1, 1, 0, 0, 1, 8, 8};
      vt[14] = '{32'hA503_0000,   1, 0, 0,   0, 0, 0, 1, 1, 8, 9};

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_tdata", 64'(m_tdata), 64'd0);
      check("rst_tlast", 64'(m_tlast), 64'd0);
      check("rst_tuser", 64'(m_tuser), 64'd0);
      check("rst_hdr_chan", 64'(hdr_chan), 64'd0);
      check("rst_pulses", 64'({hdr_valid, err_sync, err_len, err_seq}), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int k = 0; k < NV; k++) begin
         clear_mon();
         stall_mode = vt[k].stall;
         send(vt[k].hdr, vt[k].hlast);
         for (int i = 0; i < vt[k].nw; i++) send(pay(k, i), i == vt[k].nw - 1);
         stall_mode = 1'b0;
         repeat (6) @(negedge clk);
         check($sformatf("v%0d_out_count", k), 64'(out_q.size()), 64'(vt[k].exp_out));
         for (int i = 0; i < vt[k].exp_out && i < out_q.size(); i++) begin
            check($sformatf("v%0d_data%0d", k, i), 64'(out_q[i]), 64'(pay(k, i)));
            check($sformatf("v%0d_last%0d", k, i), 64'(last_q[i]), 64'(i == vt[k].exp_out - 1));
            check($sformatf("v%0d_user%0d", k, i), 64'(user_q[i]), 64'(vt[k].hdr[23:16]));
         end
         check($sformatf("v%0d_hdr_valid", k), 64'(hv_cnt), 64'(vt[k].hv));
         check($sformatf("v%0d_err_sync", k), 64'(es_cnt), 64'(vt[k].es));
         check($sformatf("v%0d_err_len", k), 64'(el_cnt), 64'(vt[k].el));
         check($sformatf("v%0d_err_seq", k), 64'(eq_cnt), 64'(vt[k].eq));
         check($sformatf("v%0d_frame_cnt", k), 64'(frame_cnt), 64'(vt[k].fc));
         check($sformatf("v%0d_err_cnt", k), 64'(err_cnt), 64'(vt[k].ec));
         if (vt[k].hv != 0) check($sformatf("v%0d_hdr_chan", k), 64'(hdr_chan), 64'(vt[k].hdr[23:16]));
         @(posedge clk); #1;
      end

      // Reset in the middle of a stalled payload.
      clear_mon();
      hold_low = 1'b1;
      @(posedge clk); #1;
      send(32'hA503_1004, 1'b0);
      send(32'hBEEF_0000, 1'b0);
      @(negedge clk);
      check("mid_tvalid_before_rst", 64'(m_tvalid), 64'd1);
      check("mid_tdata_before_rst", 64'(m_tdata), 64'hBEEF_0000);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
      check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
      check("mid_rst_hdr_chan", 64'(hdr_chan), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      hold_low = 1'b0;

      // First word after reset is a header; sequence history is forgotten.
      clear_mon();
      send(32'hA505_7002, 1'b0);
      send(32'h1234_0001, 1'b0);
      send(32'h1234_0002, 1'b1);
      repeat (6) @(negedge clk);
      check("post_rst_out_count", 64'(out_q.size()), 64'd2);
      if (out_q.size() == 2) begin
         check("post_rst_data0", 64'(out_q[0]), 64'h1234_0001);
         check("post_rst_data1", 64'(out_q[1]), 64'h1234_0002);
         check("post_rst_last1", 64'(last_q[1]), 64'd1);
         check("post_rst_user", 64'(user_q[0]), 64'd5);
      end
      check("post_rst_hdr_valid", 64'(hv_cnt), 64'd1);
      check("post_rst_err_seq", 64'(eq_cnt), 64'd0);
      check("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);
      check("post_rst_err_cnt", 64'(err_cnt), 64'd0);
      check("post_rst_hdr_chan", 64'(hdr_chan), 64'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
